// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Holds the funct3 op encodings, the FSM state encoding and the helpers
// that classify an op by its operand signedness and result kind.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } state_e;

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic is_signed_a(input logic [2:0] f3);
        logic s;
        s = 1'b0;
        case (f3)
            F3_MULH, F3_MULHSU, F3_DIV, F3_REM: s = 1'b1;
            F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: s = 1'b0;
        endcase
        return s;
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic is_signed_b(input logic [2:0] f3);
        logic s;
        s = 1'b0;
        case (f3)
            F3_MULH, F3_DIV, F3_REM:                       s = 1'b1;
            F3_MUL, F3_MULHSU, F3_MULHU, F3_DIVU, F3_REMU: s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

    function automatic logic is_rem(input logic [2:0] f3);
        return (f3 == F3_REM) || (f3 == F3_REMU);
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate of a W-bit value (combinational).
// Ports:
//   data_i    value to fix
//   neg_i     1 = negate, 0 = pass through
//   data_o_c  fixed value
module muldiv_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] data_i,
    input  logic         neg_i,
    output logic [W-1:0] data_o_c
);

    assign data_o_c = neg_i ? (~data_i + W'(1)) : data_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide over XLEN cycles, with a start/busy/done handshake.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             op request, sampled only while idle
//   funct3            M-extension op select
//   op_a, op_b        rs1 / rs2 operands
//   busy              high from PREP through FIN
//   done              one-cycle pulse with a valid result
//   result            op result, held until the next accepted start
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam int unsigned PW    = 2 * XLEN;

    state_e            state_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [PW-1:0]     acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    // Operand sign handling (meaningful in PREP, where a_q/b_q hold raw operands)
    logic            sa_c;
    logic            sb_c;
    logic [XLEN-1:0] a_abs_c;
    logic [XLEN-1:0] b_abs_c;

    assign sa_c = is_signed_a(f3_q) & a_q[XLEN-1];
    assign sb_c = is_signed_b(f3_q) & b_q[XLEN-1];

    muldiv_sign_fix #(.W(XLEN)) u_fix_a (
        .data_i   (a_q),
        .neg_i    (sa_c),
        .data_o_c (a_abs_c)
    );

    muldiv_sign_fix #(.W(XLEN)) u_fix_b (
        .data_i   (b_q),
        .neg_i    (sb_c),
        .data_o_c (b_abs_c)
    );

    // Special divide cases bypass the iteration entirely
    logic div_by_zero_c;
    logic div_ovf_c;
    logic special_c;
    logic neg_prep_c;

    assign div_by_zero_c = is_div(f3_q) & (b_q == '0);
    assign div_ovf_c     = is_div(f3_q) & is_signed_b(f3_q)
                         & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (b_q == '1);
    assign special_c     = div_by_zero_c | div_ovf_c;
    // Remainder takes the dividend's sign; product and quotient take sa^sb
    assign neg_prep_c    = is_rem(f3_q) ? sa_c : (sa_c ^ sb_c);

    // Multiply step: acc = {partial product, remaining multiplier bits}
    logic [XLEN:0]   mul_sum_c;
    logic [PW-1:0]   mul_step_c;

    assign mul_sum_c  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_step_c = {mul_sum_c, acc_q[XLEN-1:1]};

    // Divide step: acc = {partial remainder, dividend bits shifting into quotient}
    logic [XLEN:0]   div_rem_c;
    logic            div_ge_c;
    logic [XLEN-1:0] div_diff_c;
    logic [PW-1:0]   div_step_c;

    assign div_rem_c  = {acc_q[PW-1:XLEN], acc_q[XLEN-1]};
    assign div_ge_c   = div_rem_c >= {1'b0, b_q};
    // Only used when div_ge_c, so the true difference fits in XLEN bits
    assign div_diff_c = div_rem_c[XLEN-1:0] - b_q;
    assign div_step_c = {(div_ge_c ? div_diff_c : div_rem_c[XLEN-1:0]),
                         acc_q[XLEN-2:0], div_ge_c};

    // Next accumulator value and its sign flag
    logic [PW-1:0] acc_d;
    logic          neg_d;

    always_comb begin
        acc_d = acc_q;
        neg_d = neg_q;
        case (state_q)
            ST_PREP: begin
                if (div_by_zero_c) begin
                    acc_d = {a_q, {XLEN{1'b1}}};
                    neg_d = 1'b0;
                end else if (div_ovf_c) begin
                    acc_d = {{XLEN{1'b0}}, a_q};
                    neg_d = 1'b0;
                end else begin
                    acc_d = {{XLEN{1'b0}}, (is_div(f3_q) ? a_abs_c : b_abs_c)};
                    neg_d = neg_prep_c;
                end
            end
            ST_RUN:  acc_d = is_div(f3_q) ? div_step_c : mul_step_c;
            default: acc_d = acc_q;
        endcase
    end

    // Result sign correction, formed on the edge entering FIN so the
    // registered result is presented together with done
    logic [PW-1:0]   prod_fix_c;
    logic [XLEN-1:0] div_sel_c;
    logic [XLEN-1:0] div_fix_c;
    logic [XLEN-1:0] res_c;

    assign div_sel_c = is_rem(f3_q) ? acc_d[PW-1:XLEN] : acc_d[XLEN-1:0];

    muldiv_sign_fix #(.W(PW)) u_fix_prod (
        .data_i   (acc_d),
        .neg_i    (neg_d),
        .data_o_c (prod_fix_c)
    );

    muldiv_sign_fix #(.W(XLEN)) u_fix_div (
        .data_i   (div_sel_c),
        .neg_i    (neg_d),
        .data_o_c (div_fix_c)
    );

    always_comb begin
        res_c = prod_fix_c[XLEN-1:0];
        if (is_div(f3_q)) begin
            res_c = div_fix_c;
        end else if (f3_q != F3_MUL) begin
            res_c = prod_fix_c[PW-1:XLEN];
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            f3_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        f3_q    <= funct3;
                        a_q     <= op_a;
                        b_q     <= op_b;
                        busy_q  <= 1'b1;
                        state_q <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    a_q   <= a_abs_c;
                    b_q   <= b_abs_c;
                    acc_q <= acc_d;
                    neg_q <= neg_d;
                    cnt_q <= '0;
                    if (special_c) begin
                        result_q <= res_c;
                        done_q   <= 1'b1;
                        state_q  <= ST_FIN;
                    end else begin
                        state_q  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        result_q <= res_c;
                        done_q   <= 1'b1;
                        state_q  <= ST_FIN;
                    end
                end
                ST_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32): directed and random ops are
// checked for result value and done latency against an arithmetic model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] res;
        int unsigned cyc;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: RV32M semantics with plain 64-bit arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        int          ia;
        int          ib;
        logic [31:0] r;
        ia = a;
        ib = b;
        r  = '0;
        case (f3)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; r = up[31:0];  end
            3'd1: begin sp = longint'(ia) * longint'(ib); r = sp[63:32]; end
            3'd2: begin sp = longint'(ia) * longint'({32'b0, b}); r = sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = ia / ib;
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = ia % ib;
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int unsigned ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                                input logic [31:0] b);
        if (f3[2] && (b == 0)) return 2;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: got done with result %h, expected no done (cycle %0d)",
                         result, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", result, e.res);
                check("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        funct3 = f3;
        op_a   = a;
        op_b   = b;
        e.res  = ref_model(f3, a, b);
        e.cyc  = cyc + ref_latency(f3, a, b);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done within 100 cycles (cycle %0d)", cyc);
        end else begin
            check("busy_at_done", {31'b0, busy}, 32'd1);
        end
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        issue(f3, a, b);
        wait_done();
    endtask

    initial begin
        int unsigned c0;
        logic [2:0]  rf3;
        logic [31:0] ra;
        logic [31:0] rb;
        int unsigned sel;

        rst    = 1'b1;
        start  = 1'b0;
        funct3 = '0;
        op_a   = '0;
        op_b   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'b0, busy}, 32'd0);
        check("reset_done",   {31'b0, done}, 32'd0);
        check("reset_result", result,        32'd0);
        rst = 1'b0;

        // MUL with result hold after done
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        @(negedge clk);
        check("busy_idle", {31'b0, busy}, 32'd0);
        check("done_pulse", {31'b0, done}, 32'd0);
        repeat (3) @(negedge clk);
        check("result_held", result, 32'hFFFF_FFEB);

        // High-half multiplies
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);

        // Divides, back to back
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd5, 32'd100, 32'd7);
        do_op(3'd7, 32'd100, 32'd7);

        // Special divide cases
        do_op(3'd5, 32'd5, 32'd0);
        do_op(3'd7, 32'd5, 32'd0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd4, 32'd5, 32'd0);
        do_op(3'd6, 32'hFFFF_FFF0, 32'd0);

        // Start while busy is ignored
        issue(3'd0, 32'd3, 32'd4);
        repeat (8) @(negedge clk);
        start  = 1'b1;
        funct3 = 3'd4;
        op_a   = 32'd9;
        op_b   = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        do_op(3'd4, 32'd9, 32'd3);

        // Reset mid-operation: no done pulse, clean restart
        @(negedge clk);
        c0     = cyc;
        start  = 1'b1;
        funct3 = 3'd5;
        op_a   = 32'd100;
        op_b   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        while (cyc < c0 + 15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy",   {31'b0, busy}, 32'd0);
        check("rst_done",   {31'b0, done}, 32'd0);
        check("rst_result", result,        32'd0);
        repeat (40) @(negedge clk);
        do_op(3'd0, 32'd2, 32'd2);

        // Randomised ops, biased toward divide corner cases
        for (int i = 0; i < 60; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            if (sel == 3) ra = 32'($urandom_range(0, 255));
            do_op(rf3, ra, rb);
        end

        repeat (5) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d outstanding, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide unit for the RISC_32I datapath.
- Sits beside the single-cycle ALU; the ALU decoder routes funct7=0000001 R-type ops here.
- Parametrised in operand width. Executes the 8 M-extension ops over multiple cycles with a start/busy/done handshake.
- The main control stalls the pipeline while busy=1.

Parameters:
XLEN, 32, operand/result width in bits (even, >=4)
CNT_W, $clog2(XLEN)+1, iteration counter width (localparam, not overridable)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  op request; sampled only in IDLE
funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  XLEN  rs1 operand (multiplicand/dividend)
op_b  input  XLEN  rs2 operand (multiplier/divisor)
busy  output  1  high from the cycle after start is accepted through the done cycle
done  output  1  one-cycle pulse; result valid in this cycle
result  output  XLEN  op result; held stable after done until the next accepted start

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, result=0, internal registers=0. Reset mid-operation aborts immediately with no done pulse.
- FSM states: IDLE, PREP, RUN, FIN.
- IDLE:
  - start=1: latch funct3, op_a and op_b; go to PREP.
  - start=0: stay in IDLE.
- PREP (1 cycle):
  - Compute operand signs per op. MULH signs both, MULHSU signs a only, DIV/REM sign both, others unsigned.
  - Take absolute values; store the result sign.
  - Quotient sign = sa^sb. Remainder sign = sign of dividend.
  - Special divide cases go directly to FIN; all other ops go to RUN with count=0.
- Special divide cases:
  - b==0: quotient = all ones, remainder = op_a.
  - Signed overflow (a = -2^(XLEN-1), b = -1): quotient = op_a, remainder = 0.
- RUN (exactly XLEN cycles; count 0..XLEN-1, exits to FIN when count==XLEN-1):
  - Multiply: radix-2 shift-add into a 2*XLEN accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring shift-subtract, one quotient bit per cycle, MSB first.
- FIN (1 cycle): apply the sign correction (two's complement of the 2*XLEN product or of the quotient/remainder). Register result and assert done=1 for this cycle only. Next state IDLE.
  - MUL = low XLEN bits.
  - MULH/MULHSU/MULHU = high XLEN bits.
  - DIV/DIVU = quotient; REM/REMU = remainder.
- Latency, counted from the cycle start is sampled in IDLE (cycle 0):
  - Normal ops: done at cycle XLEN+2 (34 for XLEN=32).
  - Special divide cases: done at cycle 2.
- busy timing: 1 in PREP, RUN and FIN; 0 in IDLE. Back-to-back operation is allowed: start may be asserted in the cycle after done.
- start while busy=1 is ignored; the in-flight op and its operands are unaffected.
- All arithmetic is modulo 2^XLEN, except the internal 2*XLEN product. No X propagation: unused funct3 codes do not exist (all 8 are defined).

Decomposition:
- Shared package muldiv_pkg:
  - funct3 encodings as localparams (F3_MUL … F3_REMU).
  - FSM state encoding (2 bits).
  - Helper function is_signed_a/is_signed_b(funct3).
- One natural sub-module, muldiv_sign_fix: combinational conditional two's-complement negate of an XLEN/2*XLEN value. Instantiated in PREP for the operands and in FIN for the result.
- The datapath and FSM stay in muldiv_unit.

Test Plan:
1. MUL op_a=7, op_b=0xFFFFFFFD (-3), start at cycle 0 -> busy=1 cycles 1..34, done pulse at cycle 34, result=0xFFFFFFEB, held until the next start.
2. MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF(-1)*0x00000002 -> 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each done at cycle 34.
4. Special cases, each with done at cycle 2:
   - DIVU 5/0 -> 0xFFFFFFFF
   - REMU 5/0 -> 5
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
   - REM same operands -> 0
5. Start MUL 3*4, then pulse start with DIV 9/3 at cycle 10 -> second request ignored; done at 34 with result 12; a fresh start at cycle 35 yields 3 at cycle 69.
6. Start DIVU 100/7, assert rst at cycle 15 -> from cycle 16 busy=0, done=0, result=0, and no done pulse ever; a new MUL 2*2 afterwards completes normally with 4.
